// File: rtl/mul_seq_pkg.sv
// Shared types and default widths for the iterated-multiply sequencer.
package mul_seq_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        MUL   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Iterated-multiply sequencer: acc = Rs * Rm^N, written back to Rd through write port 1.
// Define MUL_SEQ_CSPR_EN to add the status-flag update outputs driven during write-back.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] rs_sel,
    input  logic [ADDR_W-1:0] rm_sel,
    input  logic [ADDR_W-1:0] rd_sel,
    input  logic [CNT_W-1:0]  iter,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wen,
    output logic [DATA_W-1:0] mul_rs,
    output logic [DATA_W-1:0] mul_rm,
    input  logic [DATA_W-1:0] mul_result
`ifdef MUL_SEQ_CSPR_EN
    ,
    input  logic [DATA_W-1:0] cspr_in,
    output logic              cspr_write,
    output logic [DATA_W-1:0] cspr_update
`endif
);

    state_e              state_r;
    logic [ADDR_W-1:0]   raddr1_r;
    logic [ADDR_W-1:0]   raddr2_r;
    logic [ADDR_W-1:0]   rd_r;
    logic [CNT_W-1:0]    iter_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   acc_r;
    logic [DATA_W-1:0]   op_r;
    logic                busy_r;
    logic                wen_r;
    logic                done_r;

    // Sequencer state, operand capture, accumulator and iteration count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            raddr1_r <= {ADDR_W{1'b0}};
            raddr2_r <= {ADDR_W{1'b0}};
            rd_r     <= {ADDR_W{1'b0}};
            iter_r   <= {CNT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            op_r     <= {DATA_W{1'b0}};
            busy_r   <= 1'b0;
            wen_r    <= 1'b0;
            done_r   <= 1'b0;
        end else if (abort && (state_r != IDLE)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            wen_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        raddr1_r <= rs_sel;
                        raddr2_r <= rm_sel;
                        rd_r     <= rd_sel;
                        iter_r   <= iter;
                        busy_r   <= 1'b1;
                        state_r  <= READ;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                READ: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    acc_r <= rf_rdata1;
                    op_r  <= rf_rdata2;
                    cnt_r <= iter_r;
                    if (iter_r == {CNT_W{1'b0}}) begin
                        wen_r   <= 1'b1;
                        state_r <= WRITE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                MUL: begin
                    acc_r <= mul_result;
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        wen_r   <= 1'b1;
                        state_r <= WRITE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                WRITE: begin
                    wen_r   <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    wen_r   <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // An abort arriving during the write or done cycle still cancels that pulse.
    assign busy      = busy_r;
    assign done      = done_r & ~abort;
    assign rf_wen    = wen_r & ~abort;
    assign rf_raddr1 = raddr1_r;
    assign rf_raddr2 = raddr2_r;
    assign rf_waddr  = rd_r;
    assign rf_wdata  = acc_r;
    assign mul_rs    = acc_r;
    assign mul_rm    = op_r;

`ifdef MUL_SEQ_CSPR_EN
    assign cspr_write  = rf_wen;
    assign cspr_update = rf_wen ? {acc_r[DATA_W-1], (acc_r == {DATA_W{1'b0}}), cspr_in[DATA_W-3:0]}
                                : {DATA_W{1'b0}};
`else
`endif

endmodule
